// File: rtl/mips_pkg.sv
// Purpose : shared definitions for the MIPS ID/EX slice (control bit map, reg zero, operand bypass helper).
// Latency : n/a (types, constants and a combinational function only).
// Backpressure: n/a.
package mips_pkg;

    // Width of the decoded control bundle carried from ID into EX.
    localparam int CTRL_W = 12;

    // Control bit map.
    localparam int CTRL_RFWR      = 0;  // instruction writes the register file
    localparam int CTRL_MEMRD     = 1;  // load: result only available after MEM
    localparam int CTRL_MEMWR     = 2;  // store
    localparam int CTRL_USE_RS    = 3;  // instruction actually reads rs
    localparam int CTRL_USE_RT    = 4;  // instruction actually reads rt
    localparam int CTRL_ALUOP_LSB = 5;  // ALU opcode, 4 bits
    localparam int CTRL_ALUOP_MSB = 8;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Operand seen by EX: r0 is hard zero, a same-cycle WB write to the
    // source register wins over the (stale) register-file read data.
    function automatic logic [31:0] bypass_operand(
        input logic [4:0]  src,
        input logic [31:0] rf_dat,
        input logic        wb_rfwr,
        input logic [4:0]  wb_w,
        input logic [31:0] wb_din
    );
        logic [31:0] res;
        res = rf_dat;
        if (src == REG_ZERO) begin
            res = 32'd0;
        end else if (wb_rfwr && (wb_w == src)) begin
            res = wb_din;
        end
        return res;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Purpose : ID/EX boundary bundle: ID instruction, rf read data, WB write port, EX register outputs.
// Latency : n/a (wires only).
// Backpressure: ex_stall from EX in, id_stall to IF/ID out.
//  master : environment side (drives ID/rf/WB/ex_stall/flush, observes id_stall and EX register)
//  slave  : the id_ex_stage itself
interface id_ex_stage_if #(
    parameter int CTRL_W = mips_pkg::CTRL_W
);
    // ID side
    logic              id_valid;
    logic [31:0]       id_pc;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic [4:0]        id_wreg;
    logic [31:0]       id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic [31:0]       rf_douta;
    logic [31:0]       rf_doutb;
    // WB write port snoop
    logic              wb_rfwr;
    logic [4:0]        wb_w;
    logic [31:0]       wb_din;
    // pipeline control
    logic              ex_stall;
    logic              flush;
    logic              id_stall;
    // EX register
    logic              ex_valid;
    logic [31:0]       ex_pc;
    logic [31:0]       ex_a;
    logic [31:0]       ex_b;
    logic [31:0]       ex_imm;
    logic [4:0]        ex_rs;
    logic [4:0]        ex_rt;
    logic [4:0]        ex_wreg;
    logic [CTRL_W-1:0] ex_ctrl;

    modport master (
        output id_valid, id_pc, id_rs, id_rt, id_wreg, id_imm, id_ctrl,
               rf_douta, rf_doutb, wb_rfwr, wb_w, wb_din, ex_stall, flush,
        input  id_stall, ex_valid, ex_pc, ex_a, ex_b, ex_imm,
               ex_rs, ex_rt, ex_wreg, ex_ctrl
    );

    modport slave (
        input  id_valid, id_pc, id_rs, id_rt, id_wreg, id_imm, id_ctrl,
               rf_douta, rf_doutb, wb_rfwr, wb_w, wb_din, ex_stall, flush,
        output id_stall, ex_valid, ex_pc, ex_a, ex_b, ex_imm,
               ex_rs, ex_rt, ex_wreg, ex_ctrl
    );

endinterface

// File: rtl/load_use_detect.sv
// Purpose : flag an ID instruction that reads the destination of a load sitting in EX.
// Latency : combinational.
// Backpressure: none itself; its output feeds id_stall and the bubble insert.
//  ports: ex_valid/ex_memrd/ex_wreg (EX register), id_valid/id_rs/id_rt/id_use_rs/id_use_rt (ID) -> lu
module load_use_detect
    import mips_pkg::*;
(
    input  logic       ex_valid,
    input  logic       ex_memrd,
    input  logic [4:0] ex_wreg,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    output logic       lu
);

    logic load_in_ex;
    logic rs_hit;
    logic rt_hit;

    // A load targeting r0 produces nothing anyone can depend on.
    assign load_in_ex = ex_valid & ex_memrd & (ex_wreg != REG_ZERO);
    assign rs_hit     = id_use_rs & (id_rs == ex_wreg);
    assign rt_hit     = id_use_rt & (id_rt == ex_wreg);
    assign lu         = id_valid & load_in_ex & (rs_hit | rt_hit);

endmodule

// File: rtl/id_ex_stage.sv
// Purpose : ID/EX pipeline register with WB->ID operand bypass, load-use bubble insert and flush squash.
// Latency : 1 cycle ID->EX; a load-use hazard costs exactly one bubble.
// Backpressure: ex_stall freezes the EX register; id_stall = ex_stall | load-use tells IF/ID to hold.
//  ports: clk, rst (sync, active high), bus (id_ex_stage_if.slave), bubble_cnt (saturating bubble count)
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int CTRL_W = mips_pkg::CTRL_W,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    id_ex_stage_if.slave     bus,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              ex_valid_q;
    logic [31:0]       ex_pc_q;
    logic [31:0]       ex_a_q;
    logic [31:0]       ex_b_q;
    logic [31:0]       ex_imm_q;
    logic [4:0]        ex_rs_q;
    logic [4:0]        ex_rt_q;
    logic [4:0]        ex_wreg_q;
    logic [CTRL_W-1:0] ex_ctrl_q;
    logic [CNT_W-1:0]  bubble_cnt_q;
    // A flush that arrives while EX is frozen must still squash the ID
    // instruction once EX can move again; this remembers it.
    logic              kill_pend_q;

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        lu;

    assign op_a = bypass_operand(bus.id_rs, bus.rf_douta, bus.wb_rfwr, bus.wb_w, bus.wb_din);
    assign op_b = bypass_operand(bus.id_rt, bus.rf_doutb, bus.wb_rfwr, bus.wb_w, bus.wb_din);

    load_use_detect u_lu (
        .ex_valid  (ex_valid_q),
        .ex_memrd  (ex_ctrl_q[CTRL_MEMRD]),
        .ex_wreg   (ex_wreg_q),
        .id_valid  (bus.id_valid),
        .id_rs     (bus.id_rs),
        .id_rt     (bus.id_rt),
        .id_use_rs (bus.id_ctrl[CTRL_USE_RS]),
        .id_use_rt (bus.id_ctrl[CTRL_USE_RT]),
        .lu        (lu)
    );

    assign bus.id_stall = bus.ex_stall | lu;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q   <= 1'b0;
            ex_pc_q      <= '0;
            ex_a_q       <= '0;
            ex_b_q       <= '0;
            ex_imm_q     <= '0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_wreg_q    <= '0;
            ex_ctrl_q    <= '0;
            kill_pend_q  <= 1'b0;
            bubble_cnt_q <= '0;
        end else if (bus.ex_stall) begin
            // EX register holds every field.
            if (bus.flush) begin
                kill_pend_q <= 1'b1;
            end
        end else if (bus.flush || kill_pend_q || lu) begin
            // Bubble. Flush has priority over load-use but both insert the
            // same single bubble, so they share this branch. Data fields are
            // left untouched: they are meaningless while ex_valid is low.
            ex_valid_q  <= 1'b0;
            ex_ctrl_q   <= '0;
            kill_pend_q <= 1'b0;
            if (bubble_cnt_q != CNT_MAX) begin
                bubble_cnt_q <= bubble_cnt_q + CNT_ONE;
            end
        end else begin
            ex_valid_q <= bus.id_valid;
            ex_pc_q    <= bus.id_pc;
            ex_a_q     <= op_a;
            ex_b_q     <= op_b;
            ex_imm_q   <= bus.id_imm;
            ex_rs_q    <= bus.id_rs;
            ex_rt_q    <= bus.id_rt;
            ex_wreg_q  <= bus.id_wreg;
            // An empty slot must not carry stray write/load enables into EX.
            ex_ctrl_q  <= bus.id_valid ? bus.id_ctrl : '0;
        end
    end

    assign bus.ex_valid = ex_valid_q;
    assign bus.ex_pc    = ex_pc_q;
    assign bus.ex_a     = ex_a_q;
    assign bus.ex_b     = ex_b_q;
    assign bus.ex_imm   = ex_imm_q;
    assign bus.ex_rs    = ex_rs_q;
    assign bus.ex_rt    = ex_rt_q;
    assign bus.ex_wreg  = ex_wreg_q;
    assign bus.ex_ctrl  = ex_ctrl_q;
    assign bubble_cnt   = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bubble_cnt;
    logic [3:0]  bubble_cnt_s;

    int n_cmp = 0;
    int n_err = 0;

    id_ex_stage_if bus ();
    id_ex_stage_if sbus ();

    id_ex_stage #(.CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .bubble_cnt (bubble_cnt)
    );

    // Narrow counter instance used only to observe saturation.
    id_ex_stage #(.CNT_W(4)) dut_s (
        .clk        (clk),
        .rst        (rst),
        .bus        (sbus),
        .bubble_cnt (bubble_cnt_s)
    );

    always #5 clk = ~clk;

    localparam logic [CTRL_W-1:0] C_ALU  = (12'd1 << CTRL_RFWR) | (12'd1 << CTRL_USE_RS) | (12'd1 << CTRL_USE_RT);
    localparam logic [CTRL_W-1:0] C_LOAD = (12'd1 << CTRL_RFWR) | (12'd1 << CTRL_MEMRD) | (12'd1 << CTRL_USE_RS);

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] wreg,
                          input logic [CTRL_W-1:0] ctrl, input logic [31:0] rfa,
                          input logic [31:0] rfb);
        bus.id_valid = v;
        bus.id_pc    = pc;
        bus.id_rs    = rs;
        bus.id_rt    = rt;
        bus.id_wreg  = wreg;
        bus.id_imm   = pc ^ 32'h5A5A_0000;
        bus.id_ctrl  = ctrl;
        bus.rf_douta = rfa;
        bus.rf_doutb = rfb;
    endtask

    task automatic set_wb(input logic wr, input logic [4:0] w, input logic [31:0] d);
        bus.wb_rfwr = wr;
        bus.wb_w    = w;
        bus.wb_din  = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Bypass vectors
    typedef struct {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] rfa;
        logic [31:0] rfb;
        logic        wb_rfwr;
        logic [4:0]  wb_w;
        logic [31:0] wb_din;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;
    vec_t vecs[7];

    // Reference model state
    logic              m_valid;
    logic [31:0]       m_pc, m_a, m_b, m_imm;
    logic [4:0]        m_rs, m_rt, m_wreg;
    logic [CTRL_W-1:0] m_ctrl;
    bit                m_known;     // data fields are defined (not a bubble)
    bit                m_kill;      // a flush seen while EX was frozen
    int                m_cnt;

    function automatic logic [31:0] ref_opnd(input logic [4:0] r, input logic [31:0] rf);
        if (r == 5'd0) return 32'd0;
        if (bus.wb_rfwr && bus.wb_w == r) return bus.wb_din;
        return rf;
    endfunction

    function automatic bit ref_hazard();
        bit reads_rs, reads_rt;
        if (!(bus.id_valid && m_valid && m_ctrl[CTRL_MEMRD] && m_wreg != 5'd0)) return 1'b0;
        reads_rs = bus.id_ctrl[CTRL_USE_RS] && (bus.id_rs == m_wreg);
        reads_rt = bus.id_ctrl[CTRL_USE_RT] && (bus.id_rt == m_wreg);
        return reads_rs || reads_rt;
    endfunction

    initial begin
        rst = 1'b1;
        set_id(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, '0, 32'd0, 32'd0);
        set_wb(1'b0, 5'd0, 32'd0);
        bus.ex_stall = 1'b0;
        bus.flush    = 1'b0;
        sbus.id_valid = 1'b0; sbus.id_pc = '0; sbus.id_rs = '0; sbus.id_rt = '0;
        sbus.id_wreg = '0; sbus.id_imm = '0; sbus.id_ctrl = '0; sbus.rf_douta = '0;
        sbus.rf_doutb = '0; sbus.wb_rfwr = 1'b0; sbus.wb_w = '0; sbus.wb_din = '0;
        sbus.ex_stall = 1'b0; sbus.flush = 1'b0;

        vecs[0] = '{5'd3, 5'd4, 32'h11, 32'h22, 1'b0, 5'd3, 32'hDEAD, 32'h11,   32'h22};
        vecs[1] = '{5'd3, 5'd4, 32'h11, 32'h22, 1'b1, 5'd3, 32'hDEAD, 32'hDEAD, 32'h22};
        vecs[2] = '{5'd3, 5'd4, 32'h11, 32'h22, 1'b1, 5'd4, 32'hBEEF, 32'h11,   32'hBEEF};
        vecs[3] = '{5'd0, 5'd4, 32'h11, 32'h22, 1'b1, 5'd0, 32'hDEAD, 32'h0,    32'h22};
        vecs[4] = '{5'd6, 5'd6, 32'h33, 32'h44, 1'b1, 5'd6, 32'hCAFE, 32'hCAFE, 32'hCAFE};
        vecs[5] = '{5'd3, 5'd0, 32'h11, 32'h99, 1'b0, 5'd3, 32'hDEAD, 32'h11,   32'h0};
        vecs[6] = '{5'd31, 5'd30, 32'h7, 32'h8, 1'b1, 5'd29, 32'hF00D, 32'h7,   32'h8};

        do_reset();

        // Reset state
        chk("rst_ex_valid", bus.ex_valid, 1'b0);
        chk("rst_ex_fields", {bus.ex_pc, bus.ex_a, bus.ex_b, bus.ex_imm}, 128'd0);
        chk("rst_ex_regs_ctrl", {bus.ex_rs, bus.ex_rt, bus.ex_wreg, bus.ex_ctrl}, 27'd0);
        chk("rst_bubble_cnt", bubble_cnt, 16'd0);
        chk("rst_id_stall", bus.id_stall, 1'b0);

        // Saturation on the 4-bit counter instance
        for (int k = 1; k <= 20; k++) begin
            sbus.flush = 1'b1;
            tick();
            chk("sat_count", bubble_cnt_s, (k > 15) ? 4'd15 : 4'(k));
        end
        sbus.flush = 1'b0;
        tick();
        chk("sat_hold", bubble_cnt_s, 4'd15);

        // Table: operand bypass
        for (int i = 0; i < 7; i++) begin
            set_id(1'b1, 32'h1000 + 32'(4 * i), vecs[i].rs, vecs[i].rt, 5'd9, C_ALU,
                   vecs[i].rfa, vecs[i].rfb);
            set_wb(vecs[i].wb_rfwr, vecs[i].wb_w, vecs[i].wb_din);
            tick();
            chk("vec_ex_a", bus.ex_a, vecs[i].exp_a);
            chk("vec_ex_b", bus.ex_b, vecs[i].exp_b);
            chk("vec_ex_valid", bus.ex_valid, 1'b1);
        end
        set_wb(1'b0, 5'd0, 32'd0);

        // Load-use: lw $5 then add using $5
        do_reset();
        set_id(1'b1, 32'h40, 5'd1, 5'd0, 5'd5, C_LOAD, 32'h1, 32'h0);
        tick();
        chk("lu_lw_in_ex", {bus.ex_valid, bus.ex_wreg}, {1'b1, 5'd5});
        set_id(1'b1, 32'h44, 5'd5, 5'd2, 5'd7, C_ALU, 32'h5, 32'h2);
        #1;
        chk("lu_id_stall", bus.id_stall, 1'b1);
        tick();
        chk("lu_bubble_valid", bus.ex_valid, 1'b0);
        chk("lu_bubble_ctrl", bus.ex_ctrl, 12'd0);
        chk("lu_bubble_cnt", bubble_cnt, 16'd1);
        chk("lu_stall_released", bus.id_stall, 1'b0);
        tick();
        chk("lu_add_enters", {bus.ex_valid, bus.ex_pc, bus.ex_wreg}, {1'b1, 32'h44, 5'd7});
        chk("lu_single_bubble", bubble_cnt, 16'd1);

        // Flush together with load-use: one bubble only
        set_id(1'b1, 32'h48, 5'd1, 5'd0, 5'd5, C_LOAD, 32'h1, 32'h0);
        tick();
        set_id(1'b1, 32'h4C, 5'd5, 5'd2, 5'd7, C_ALU, 32'h5, 32'h2);
        bus.flush = 1'b1;
        #1;
        chk("fl_lu_id_stall", bus.id_stall, 1'b1);
        tick();
        bus.flush = 1'b0;
        chk("fl_lu_bubble", {bus.ex_valid, bubble_cnt}, {1'b0, 16'd2});
        set_id(1'b1, 32'h50, 5'd1, 5'd2, 5'd8, C_ALU, 32'h1, 32'h2);
        tick();
        chk("fl_lu_next_loads", {bus.ex_valid, bus.ex_pc, bubble_cnt}, {1'b1, 32'h50, 16'd2});

        // EX stall for 3 cycles with a flush in the middle
        set_id(1'b1, 32'h54, 5'd1, 5'd2, 5'd8, C_ALU, 32'h1, 32'h2);
        bus.ex_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            bus.flush = (c == 1);
            #1;
            chk("stall_id_stall", bus.id_stall, 1'b1);
            tick();
            chk("stall_hold", {bus.ex_valid, bus.ex_pc, bubble_cnt}, {1'b1, 32'h50, 16'd2});
        end
        bus.flush = 1'b0;
        bus.ex_stall = 1'b0;
        tick();
        chk("stall_release_bubble", {bus.ex_valid, bus.ex_ctrl, bubble_cnt}, {1'b0, 12'd0, 16'd3});
        tick();
        chk("stall_after_bubble", {bus.ex_valid, bus.ex_pc, bubble_cnt}, {1'b1, 32'h54, 16'd3});

        // Reset while stalled with a pending kill
        bus.ex_stall = 1'b1;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        rst = 1'b1;
        tick();
        chk("rst_stall_valid", bus.ex_valid, 1'b0);
        chk("rst_stall_fields", {bus.ex_pc, bus.ex_a, bus.ex_b, bus.ex_imm}, 128'd0);
        chk("rst_stall_regs", {bus.ex_rs, bus.ex_rt, bus.ex_wreg, bus.ex_ctrl, bubble_cnt}, 43'd0);
        rst = 1'b0;
        bus.ex_stall = 1'b0;
        set_id(1'b1, 32'h200, 5'd1, 5'd2, 5'd3, C_ALU, 32'h1, 32'h2);
        tick();
        chk("rst_kill_cleared", {bus.ex_valid, bus.ex_pc, bubble_cnt}, {1'b1, 32'h200, 16'd0});

        // Randomized run against the reference model
        do_reset();
        m_valid = 0; m_pc = 0; m_a = 0; m_b = 0; m_imm = 0;
        m_rs = 0; m_rt = 0; m_wreg = 0; m_ctrl = 0; m_known = 1; m_kill = 0; m_cnt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit hz;
            rst = ($urandom_range(0, 149) == 0);
            bus.ex_stall = ($urandom_range(0, 3) == 0);
            bus.flush    = ($urandom_range(0, 7) == 0);
            set_id($urandom_range(0, 4) != 0, $urandom, 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   12'($urandom), $urandom, $urandom);
            set_wb($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
            #1;
            hz = ref_hazard();
            chk("rnd_id_stall", bus.id_stall, bus.ex_stall || hz);

            if (rst) begin
                m_valid = 0; m_pc = 0; m_a = 0; m_b = 0; m_imm = 0;
                m_rs = 0; m_rt = 0; m_wreg = 0; m_ctrl = 0; m_known = 1; m_kill = 0; m_cnt = 0;
            end else if (bus.ex_stall) begin
                if (bus.flush) m_kill = 1;
            end else if (bus.flush || m_kill || hz) begin
                m_valid = 0; m_ctrl = 0; m_known = 0; m_kill = 0;
                m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
            end else begin
                m_valid = bus.id_valid;
                m_pc    = bus.id_pc;
                m_a     = ref_opnd(bus.id_rs, bus.rf_douta);
                m_b     = ref_opnd(bus.id_rt, bus.rf_doutb);
                m_imm   = bus.id_imm;
                m_rs    = bus.id_rs;
                m_rt    = bus.id_rt;
                m_wreg  = bus.id_wreg;
                m_ctrl  = bus.id_valid ? bus.id_ctrl : '0;
                m_known = 1;
            end

            tick();
            chk("rnd_ex_valid", bus.ex_valid, m_valid);
            chk("rnd_ex_ctrl", bus.ex_ctrl, m_ctrl);
            chk("rnd_bubble_cnt", bubble_cnt, 16'(m_cnt));
            if (m_known) begin
                chk("rnd_ex_data", {bus.ex_pc, bus.ex_a, bus.ex_b, bus.ex_imm},
                    {m_pc, m_a, m_b, m_imm});
                chk("rnd_ex_regs", {bus.ex_rs, bus.ex_rt, bus.ex_wreg}, {m_rs, m_rt, m_wreg});
            end
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
